kinase_pump_sequencer: RTL and testbench
========================================

Name: kinase_pump_sequencer

Overview:
- Parametrised valve/pump sequencer for the kinase-activity chip family. It generates the ctrl, pump and flush pad patterns that are currently hand-driven.
- It accepts one command at a time over a valid/ready handshake. Each command either opens a valve set and runs one 3-membrane peristaltic pump for N cycles (forward or reverse), or asserts flush lines for the equivalent duration.
- It sits between the host controller and the pad ring of kinase_activity_pads-style top levels, and scales to any pump and valve count.

Parameters:
- NUM_PUMPS, 3, number of 3-membrane peristaltic pumps.
- NUM_VALVES, 13, number of ctrl_a valves, matched 1:1 by flush lines.
- CYCLE_W, 8, width of the pump cycle count.
- DWELL_W, 8, width of the per-step dwell count.
- SEL_W, $clog2(NUM_PUMPS) (minimum 1), width of the pump select.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_flush  in  1  1 = flush command, 0 = pump command.
- cmd_pump  in  SEL_W  pump index.
- cmd_reverse  in  1  run the step sequence backwards.
- cmd_cycles  in  CYCLE_W  full 6-step cycles to run.
- cmd_valves  in  NUM_VALVES  valve/flush mask.
- cmd_dwell  in  DWELL_W  each step is held cmd_dwell+1 clocks.
- pad_ctrl_a  out  NUM_VALVES  valve actuation.
- pad_pump_a  out  3*NUM_PUMPS  membrane actuation; pump p uses bits [3p+2:3p].
- pad_flush_ctrl_a  out  NUM_VALVES  flush actuation.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  valid only with done; 1 = cmd_pump out of range.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE. A reset mid-operation aborts the command: outputs are zero on the next edge, done is not pulsed.
- All outputs are registered.
- Accept: on the clk edge where cmd_valid && cmd_ready, latch all cmd_* fields and leave IDLE.
  - cmd_ready drops the following cycle.
  - Input changes while busy are ignored.
- States: IDLE -> SETUP -> (PUMP | FLUSH) -> SETTLE -> IDLE.
- Out-of-range pump (cmd_pump >= NUM_PUMPS, pump mode only): IDLE -> SETTLE directly. pad_* stays 0. done=1 and err=1 at SETTLE exit.
- SETUP:
  - Pump mode: pad_ctrl_a=latched valves.
  - Flush mode: pad_ctrl_a=0.
  - Held cmd_dwell+1 clocks.
- PUMP:
  - Selected pump steps through pattern (bit2..bit0): S0=100, S1=110, S2=010, S3=011, S4=001, S5=101.
  - Forward order is S0..S5; reverse order is S5..S0.
  - Each step lasts cmd_dwell+1 clocks. One cycle = 6 steps.
  - Total PUMP duration = cmd_cycles*6*(cmd_dwell+1) clocks.
  - Non-selected pumps are 000. pad_ctrl_a stays at the valve mask.
- FLUSH:
  - pad_flush_ctrl_a=latched mask, pad_ctrl_a=0, all pumps 000.
  - Same duration formula as PUMP.
- cmd_cycles=0: PUMP/FLUSH is skipped (SETUP -> SETTLE).
- SETTLE:
  - All pad outputs 0.
  - Held cmd_dwell+1 clocks.
  - done pulses on the last SETTLE clock, concurrently with the transition to IDLE.
  - cmd_ready=1 the next cycle.
- Counters:
  - Dwell counter is DWELL_W bits and counts down from cmd_dwell to 0.
  - Step counter is mod 6 and wraps S5->S0 (forward) or S0->S5 (reverse).
  - Cycle counter is CYCLE_W bits and decrements at the wrap. The maximum count 2^CYCLE_W-1 must not overflow.
- Back-to-back: a command presented in the IDLE cycle after done is accepted immediately. Minimum gap between commands is 1 IDLE cycle.
- Valve and flush outputs are never simultaneously nonzero for the same bit.

Test Plan:
- Reset check: reset for 3 clocks, then check all pad outputs 0, cmd_ready=1, busy=0, done=0.
- Forward pump run, dwell 0: pump=1, cycles=2, dwell=0, valves=13'h0005.
  - pad_ctrl_a=0005 for 1 clock.
  - pad_pump_a[5:3] runs 100,110,010,011,001,101 twice (12 clocks) while bits [2:0] and [8:6] stay 0.
  - 1 SETTLE clock, then done=1, err=0.
  - Total busy = 14 clocks.
- Reverse pump, dwell 2: pump=0, reverse=1, cycles=1, dwell=2 -> membranes 101,001,011,010,110,100, each held 3 clocks, done after 3+18+3 clocks.
- Flush run: flush=1, valves=13'h1FFF, cycles=1, dwell=1.
  - pad_flush_ctrl_a=1FFF for 12 clocks.
  - pad_ctrl_a and pad_pump_a stay 0 throughout.
  - done after 2+12+2 clocks.
- Edge cases, checked in turn:
  - pump=3 with NUM_PUMPS=3 -> no pad activity, done=1, err=1.
  - cycles=0 -> SETUP then SETTLE only.
  - cmd_valid held high with changing fields while busy -> only the first command executes.
- Reset mid-PUMP at step S3, then back-to-back commands.
  - After the reset, outputs are 0 next clock with no done pulse.
  - Next command accepted in the first IDLE cycle.
  - A second command presented 1 clock after done is accepted on that edge.

Source files
------------

// File: rtl/kinase_pump_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : kinase_pump_sequencer_if
// Description : Command handshake and pad-ring bundle for the pump sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface kinase_pump_sequencer_if #(
    parameter int NUM_PUMPS  = 3,
    parameter int NUM_VALVES = 13,
    parameter int CYCLE_W    = 8,
    parameter int DWELL_W    = 8,
    parameter int SEL_W      = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1
) ();
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_flush;
    logic [SEL_W-1:0]        cmd_pump;
    logic                    cmd_reverse;
    logic [CYCLE_W-1:0]      cmd_cycles;
    logic [NUM_VALVES-1:0]   cmd_valves;
    logic [DWELL_W-1:0]      cmd_dwell;
    logic [NUM_VALVES-1:0]   pad_ctrl_a;
    logic [3*NUM_PUMPS-1:0]  pad_pump_a;
    logic [NUM_VALVES-1:0]   pad_flush_ctrl_a;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output cmd_valid, cmd_flush, cmd_pump, cmd_reverse, cmd_cycles,
               cmd_valves, cmd_dwell,
        input  cmd_ready, pad_ctrl_a, pad_pump_a, pad_flush_ctrl_a,
               busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_flush, cmd_pump, cmd_reverse, cmd_cycles,
               cmd_valves, cmd_dwell,
        output cmd_ready, pad_ctrl_a, pad_pump_a, pad_flush_ctrl_a,
               busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/kinase_pump_sequencer.sv
//------------------------------------------------------------------------------
// Module      : kinase_pump_sequencer
// Description : One-command-at-a-time valve/peristaltic-pump/flush sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module kinase_pump_sequencer #(
    parameter int NUM_PUMPS  = 3,
    parameter int NUM_VALVES = 13,
    parameter int CYCLE_W    = 8,
    parameter int DWELL_W    = 8,
    parameter int SEL_W      = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    kinase_pump_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PUMP   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_flush;
    logic [SEL_W-1:0]        r_pump;
    logic                    r_reverse;
    logic [NUM_VALVES-1:0]   r_valves;
    logic [DWELL_W-1:0]      r_dwell;
    logic [DWELL_W-1:0]      r_dwell_cnt;
    logic [CYCLE_W-1:0]      r_cycles_left;
    logic [2:0]              r_step;
    logic                    r_bad;

    logic                    r_cmd_ready;
    logic [NUM_VALVES-1:0]   r_pad_ctrl_a;
    logic [3*NUM_PUMPS-1:0]  r_pad_pump_a;
    logic [NUM_VALVES-1:0]   r_pad_flush_ctrl_a;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;

    logic                    w_cmd_bad;
    logic                    w_dwell_zero;
    logic                    w_last_step;
    logic [2:0]              w_next_step;
    logic [2:0]              w_first_step;

    function automatic logic [2:0] step_pattern(input logic [2:0] step);
        logic [2:0] pat;
        case (step)
            3'd0:    pat = 3'b100;
            3'd1:    pat = 3'b110;
            3'd2:    pat = 3'b010;
            3'd3:    pat = 3'b011;
            3'd4:    pat = 3'b001;
            3'd5:    pat = 3'b101;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    // Only the selected pump's membrane triple is driven; all others stay 000.
    function automatic logic [3*NUM_PUMPS-1:0] pump_vector(input logic [SEL_W-1:0] sel,
                                                           input logic [2:0]       step);
        logic [3*NUM_PUMPS-1:0] vec;
        vec = '0;
        for (int p = 0; p < NUM_PUMPS; p++) begin
            if (int'(sel) == p) begin
                vec[3*p +: 3] = step_pattern(step);
            end
        end
        return vec;
    endfunction

    assign w_cmd_bad    = !bus.cmd_flush && (int'(bus.cmd_pump) >= NUM_PUMPS);
    assign w_dwell_zero = (r_dwell_cnt == '0);
    assign w_first_step = r_reverse ? 3'd5 : 3'd0;
    assign w_last_step  = r_reverse ? (r_step == 3'd0) : (r_step == 3'd5);
    assign w_next_step  = w_last_step ? w_first_step
                        : (r_reverse ? r_step - 3'd1 : r_step + 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= ST_IDLE;
            r_flush            <= 1'b0;
            r_pump             <= '0;
            r_reverse          <= 1'b0;
            r_valves           <= '0;
            r_dwell            <= '0;
            r_dwell_cnt        <= '0;
            r_cycles_left      <= '0;
            r_step             <= '0;
            r_bad              <= 1'b0;
            r_cmd_ready        <= 1'b1;
            r_pad_ctrl_a       <= '0;
            r_pad_pump_a       <= '0;
            r_pad_flush_ctrl_a <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_err              <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_flush       <= bus.cmd_flush;
                        r_pump        <= bus.cmd_pump;
                        r_reverse     <= bus.cmd_reverse;
                        r_valves      <= bus.cmd_valves;
                        r_dwell       <= bus.cmd_dwell;
                        r_dwell_cnt   <= bus.cmd_dwell;
                        r_cycles_left <= bus.cmd_cycles;
                        r_bad         <= w_cmd_bad;
                        r_busy        <= 1'b1;
                        r_cmd_ready   <= 1'b0;
                        if (w_cmd_bad) begin
                            // Bad pump index: skip straight to the settle hold.
                            r_state <= ST_SETTLE;
                            r_done  <= (bus.cmd_dwell == '0);
                            r_err   <= (bus.cmd_dwell == '0);
                        end else begin
                            r_state      <= ST_SETUP;
                            r_pad_ctrl_a <= bus.cmd_flush ? '0 : bus.cmd_valves;
                        end
                    end
                end

                ST_SETUP: begin
                    if (!w_dwell_zero) begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                    end else begin
                        r_dwell_cnt <= r_dwell;
                        r_step      <= w_first_step;
                        if (r_cycles_left == '0) begin
                            r_state      <= ST_SETTLE;
                            r_pad_ctrl_a <= '0;
                            r_done       <= (r_dwell == '0);
                        end else if (r_flush) begin
                            r_state            <= ST_FLUSH;
                            r_pad_ctrl_a       <= '0;
                            r_pad_flush_ctrl_a <= r_valves;
                        end else begin
                            r_state      <= ST_PUMP;
                            r_pad_pump_a <= pump_vector(r_pump, w_first_step);
                        end
                    end
                end

                ST_PUMP, ST_FLUSH: begin
                    if (!w_dwell_zero) begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                    end else begin
                        r_dwell_cnt <= r_dwell;
                        if (w_last_step && (r_cycles_left == CYCLE_W'(1))) begin
                            r_state            <= ST_SETTLE;
                            r_pad_ctrl_a       <= '0;
                            r_pad_pump_a       <= '0;
                            r_pad_flush_ctrl_a <= '0;
                            r_done             <= (r_dwell == '0);
                        end else begin
                            // Counting down from the latched count keeps the max value safe.
                            if (w_last_step) begin
                                r_cycles_left <= r_cycles_left - CYCLE_W'(1);
                            end
                            r_step <= w_next_step;
                            if (r_state == ST_PUMP) begin
                                r_pad_pump_a <= pump_vector(r_pump, w_next_step);
                            end
                        end
                    end
                end

                ST_SETTLE: begin
                    if (!w_dwell_zero) begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                        if (r_dwell_cnt == DWELL_W'(1)) begin
                            r_done <= 1'b1;
                            r_err  <= r_bad;
                        end
                    end else begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_bad       <= 1'b0;
                    end
                end

                default: begin
                    r_state            <= ST_IDLE;
                    r_busy             <= 1'b0;
                    r_cmd_ready        <= 1'b1;
                    r_pad_ctrl_a       <= '0;
                    r_pad_pump_a       <= '0;
                    r_pad_flush_ctrl_a <= '0;
                end
            endcase
        end
    end

    assign bus.cmd_ready        = r_cmd_ready;
    assign bus.pad_ctrl_a       = r_pad_ctrl_a;
    assign bus.pad_pump_a       = r_pad_pump_a;
    assign bus.pad_flush_ctrl_a = r_pad_flush_ctrl_a;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.err              = r_err;

endmodule

`default_nettype wire

// File: tb/tb_kinase_pump_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_kinase_pump_sequencer
// Description : Randomised self-checking bench with a per-cycle trace model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_kinase_pump_sequencer;

    localparam int NP = 3;
    localparam int NV = 13;
    localparam int CW = 8;
    localparam int DW = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kinase_pump_sequencer_if #(
        .NUM_PUMPS(NP), .NUM_VALVES(NV), .CYCLE_W(CW), .DWELL_W(DW), .SEL_W(SW)
    ) bus ();

    kinase_pump_sequencer #(
        .NUM_PUMPS(NP), .NUM_VALVES(NV), .CYCLE_W(CW), .DWELL_W(DW), .SEL_W(SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NV-1:0]   ctrl;
        logic [3*NP-1:0] pump;
        logic [NV-1:0]   flush;
        logic            done;
        logic            err;
    } exp_t;

    exp_t trace[$];

    function automatic logic [2:0] membrane(input int k);
        logic [2:0] table_v [6];
        table_v = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        return table_v[k];
    endfunction

    function automatic void push_n(input int n, input logic [NV-1:0] c, input logic [3*NP-1:0] p,
                                   input logic [NV-1:0] f, input bit last_done, input bit bad);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.ctrl  = c;
            e.pump  = p;
            e.flush = f;
            e.done  = last_done && (i == n - 1);
            e.err   = bad && (i == n - 1);
            trace.push_back(e);
        end
    endfunction

    // Expected pad activity for every clock the command is in flight.
    function automatic void build(input bit fl, input int pump, input bit rev, input int cyc,
                                  input logic [NV-1:0] valves, input int dwell);
        bit bad;
        trace.delete();
        bad = !fl && (pump >= NP);
        if (!bad) begin
            push_n(dwell + 1, fl ? '0 : valves, '0, '0, 1'b0, 1'b0);
            for (int c = 0; c < cyc; c++) begin
                for (int k = 0; k < 6; k++) begin
                    logic [3*NP-1:0] pv;
                    pv = '0;
                    if (!fl) pv[3*pump +: 3] = membrane(rev ? 5 - k : k);
                    if (fl) push_n(dwell + 1, '0, '0, valves, 1'b0, 1'b0);
                    else    push_n(dwell + 1, valves, pv, '0, 1'b0, 1'b0);
                end
            end
        end
        push_n(dwell + 1, '0, '0, '0, 1'b1, bad);
    endfunction

    task automatic randomize_fields();
        bus.cmd_flush   = 1'($urandom_range(0, 1));
        bus.cmd_pump    = SW'($urandom_range(0, 3));
        bus.cmd_reverse = 1'($urandom_range(0, 1));
        bus.cmd_cycles  = CW'($urandom_range(0, 255));
        bus.cmd_valves  = NV'($urandom);
        bus.cmd_dwell   = DW'($urandom_range(0, 255));
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.pad_ctrl_a, bus.pad_pump_a,
             bus.pad_flush_ctrl_a} !== {1'b1, 1'b1 ^ 1'b1, 1'b0, 1'b0, NV'(0), (3*NP)'(0), NV'(0)})
            begin
            failures++;
            $display("FAIL %s idle: got ready=%b busy=%b done=%b err=%b ctrl=%h pump=%h flush=%h, want ready=1 busy=0 done=0 err=0 pads=0",
                     name, bus.cmd_ready, bus.busy, bus.done, bus.err, bus.pad_ctrl_a,
                     bus.pad_pump_a, bus.pad_flush_ctrl_a);
        end
    endtask

    // Present a command at +1 after an edge; leaves the DUT in the IDLE cycle after done.
    task automatic run_cmd(input string name, input bit fl, input int pump, input bit rev,
                           input int cyc, input logic [NV-1:0] valves, input int dwell,
                           input bit hold, input int abort_at);
        build(fl, pump, rev, cyc, valves, dwell);
        bus.cmd_valid   = 1'b1;
        bus.cmd_flush   = fl;
        bus.cmd_pump    = SW'(pump);
        bus.cmd_reverse = rev;
        bus.cmd_cycles  = CW'(cyc);
        bus.cmd_valves  = valves;
        bus.cmd_dwell   = DW'(dwell);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: got cmd_ready=%b, want 1", name, bus.cmd_ready);
        end
        @(posedge clk); #1;
        for (int i = 0; i < trace.size(); i++) begin
            if (i == abort_at) begin
                bus.cmd_valid = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_idle({name, "_after_reset"});
                return;
            end
            if (hold) begin
                bus.cmd_valid = 1'b1;
                randomize_fields();
            end else begin
                bus.cmd_valid = 1'b0;
            end
            checks++;
            if ({bus.pad_ctrl_a, bus.pad_pump_a, bus.pad_flush_ctrl_a, bus.busy, bus.cmd_ready,
                 bus.done, bus.err} !== {trace[i].ctrl, trace[i].pump, trace[i].flush, 1'b1,
                 1'b0, trace[i].done, trace[i].err} || (bus.pad_ctrl_a & bus.pad_flush_ctrl_a) != '0)
                begin
                failures++;
                $display("FAIL %s cyc%0d: got ctrl=%h pump=%b flush=%h busy=%b ready=%b done=%b err=%b, want ctrl=%h pump=%b flush=%h busy=1 ready=0 done=%b err=%b",
                         name, i, bus.pad_ctrl_a, bus.pad_pump_a, bus.pad_flush_ctrl_a, bus.busy,
                         bus.cmd_ready, bus.done, bus.err, trace[i].ctrl, trace[i].pump,
                         trace[i].flush, trace[i].done, trace[i].err);
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        check_idle(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");
    endtask

    task automatic test_forward();
        run_cmd("forward_d0", 1'b0, 1, 1'b0, 2, 13'h0005, 0, 1'b0, -1);
    endtask

    task automatic test_reverse();
        run_cmd("reverse_d2", 1'b0, 0, 1'b1, 1, 13'h0A5A, 2, 1'b0, -1);
    endtask

    task automatic test_flush();
        run_cmd("flush_d1", 1'b1, 0, 1'b0, 1, 13'h1FFF, 1, 1'b0, -1);
    endtask

    task automatic test_edge_cases();
        run_cmd("bad_pump", 1'b0, 3, 1'b0, 2, 13'h1234, 0, 1'b0, -1);
        run_cmd("bad_pump_d2", 1'b0, 3, 1'b1, 1, 13'h0F0F, 2, 1'b0, -1);
        run_cmd("zero_cycles", 1'b0, 2, 1'b0, 0, 13'h0777, 1, 1'b0, -1);
        run_cmd("busy_ignore", 1'b0, 2, 1'b0, 2, 13'h0101, 1, 1'b1, -1);
        run_cmd("max_cycles", 1'b0, 2, 1'b1, 255, 13'h0003, 0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_and_back_to_back();
        // Forward dwell 1: SETUP 2 clocks, S3 starts 3 steps later.
        run_cmd("reset_mid", 1'b0, 2, 1'b0, 3, 13'h00FF, 1, 1'b0, 2 + 3 * 2);
        run_cmd("b2b_first", 1'b0, 0, 1'b0, 1, 13'h0011, 0, 1'b0, -1);
        run_cmd("b2b_second", 1'b1, 1, 1'b0, 1, 13'h1100, 0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_cmd($sformatf("rand%0d", n), ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), NV'($urandom),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_flush   = 1'b0;
        bus.cmd_pump    = '0;
        bus.cmd_reverse = 1'b0;
        bus.cmd_cycles  = '0;
        bus.cmd_valves  = '0;
        bus.cmd_dwell   = '0;
        test_reset();
        test_forward();
        test_reverse();
        test_flush();
        test_edge_cases();
        test_reset_mid_and_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
